button_debounce_pulse: RTL
==========================

Name: button_debounce_pulse

Overview:
- Sits directly downstream of the 4-bit button synchroniser and consumes its already-synchronised `sync_sig` bus.
- Produces debounced button levels plus single-cycle press pulses for the craps game FSM, e.g. roll and new-game.
- All channels are independent and identical.
- Only settled, edge-detected button events reach the game logic.

Parameters:
- WIDTH, 4, number of button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive clock edges an input must differ from the stable level before the change is accepted (10 ms at 100 MHz). Must be ≥ 1.
- CNT_W, derived localparam = $clog2(DEBOUNCE_CYCLES+1); not user-set.

Ports:
- Clk100MHz  input  1  system clock, 100 MHz, sole clock.
- reset  input  1  synchronous, active-high reset.
- sync_sig  input  WIDTH  synchronised raw button levels from the synchroniser stage.
- btn_level  output  WIDTH  debounced button level, registered.
- press_pulse  output  WIDTH  one-cycle high on each accepted 0→1 transition, registered.
- release_pulse  output  WIDTH  one-cycle high on each accepted 1→0 transition (see Optional Feature).

Behaviour:
- Reset (reset=1 at a rising edge of Clk100MHz):
  - btn_level, press_pulse, release_pulse, and all channel counters clear to 0.
  - Reset overrides every other action.
  - Reset mid-count aborts the count; no pulse is produced.
- Per-channel state is a stable level bit (drives btn_level[i]) and a counter cnt[i], CNT_W bits wide.
- Each clock edge, per channel i:
  - If sync_sig[i] == btn_level[i]: cnt[i] <= 0. Any glitch shorter than DEBOUNCE_CYCLES is discarded.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: btn_level[i] <= sync_sig[i] and cnt[i] <= 0.
    - press_pulse[i] <= sync_sig[i].
    - release_pulse[i] <= ~sync_sig[i] (only when the feature is enabled).
  - Else: cnt[i] <= cnt[i]+1.
- Pulses default to 0 every cycle unless set by the accept rule above, so each lasts exactly one cycle.
- Latency: sync_sig[i] changes before edge 1 and holds. btn_level[i] and the pulse update at edge DEBOUNCE_CYCLES and are visible after it.
- DEBOUNCE_CYCLES=1 degenerates to a one-cycle registered edge detector.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Simultaneous acceptance on several channels produces simultaneous pulses; there is no arbitration.
- A held button gives exactly one press_pulse. It gives no further pulse until it is released and the release is accepted.
- After reset, a button already held (sync_sig=1) is treated as a new press: it pulses after DEBOUNCE_CYCLES edges.

Optional Feature:
- Macro: DEBOUNCE_RELEASE_PULSE_EN.
- Defined: release_pulse is generated per the rule above.
- Undefined: release_pulse is tied to constant 0 and its register logic is not built. The port remains for interface stability.
- btn_level and press_pulse behave identically in both builds.

Decomposition:
- Shared package craps_pkg holds:
  - BTN_W = 4.
  - DEBOUNCE_10MS = 1000000.
  - Button index constants: BTN_ROLL=0, BTN_NEWGAME=1, BTN_SPARE2=2, BTN_SPARE3=3.
- One sub-module is natural: debounce_chan, a single-bit channel with its counter, stable level and pulse registers.
  - The top instantiates it WIDTH times in a generate loop.
  - The optional feature is handled inside debounce_chan.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset: drive sync_sig=4'hF with reset=1 for 3 cycles → all outputs 0. Release reset, hold 4'hF → btn_level=4'hF and press_pulse=4'hF for exactly 1 cycle, after edge 4.
- Glitch reject: on bit 0, pulse sync_sig high for 3 cycles then low → btn_level and press_pulse stay 0 throughout. Then hold high for 4 cycles → press_pulse[0]=1 for one cycle.
- Hold/release:
  - Hold bit 1 high for 20 cycles → exactly one press_pulse[1].
  - Then drive low for 4 cycles → btn_level[1]=0.
  - With DEBOUNCE_RELEASE_PULSE_EN: release_pulse[1] high for one cycle.
  - Without the macro: release_pulse stays 0.
- Simultaneous: bits 0 and 3 rise on the same cycle → press_pulse=4'b1001 in one cycle. Bit 2 rising 2 cycles later → pulses 2 cycles after that.
- Reset mid-count: raise bit 2, assert reset at count 2 for 1 cycle, keep bit 2 high → no pulse until 4 full cycles after reset deasserts.
- Degenerate (DEBOUNCE_CYCLES=1): toggle bit 0 0→1→1→0 → press_pulse[0] on the edge after the rise, and btn_level follows sync_sig with 1-cycle delay.

Source files
------------

// File: rtl/craps_pkg.sv
// Shared constants for the craps game front end.
// Holds the button bus width, the 10 ms debounce interval at 100 MHz and
// the button channel index assignments used by the game FSM.
package craps_pkg;

  localparam int unsigned BTN_W         = 4;
  localparam int unsigned DEBOUNCE_10MS = 1000000;

  // Button channel indices within the BTN_W-wide bus
  localparam int unsigned BTN_ROLL    = 0;
  localparam int unsigned BTN_NEWGAME = 1;
  localparam int unsigned BTN_SPARE2  = 2;
  localparam int unsigned BTN_SPARE3  = 3;

endpackage

// File: rtl/debounce_chan.sv
// Single-bit debounce channel: stable level register, run-length counter
// and one-cycle press/release pulse registers.
// A change on sync_sig is accepted only after it has differed from the
// stable level for DEBOUNCE_CYCLES consecutive clock edges.
// Optional macro DEBOUNCE_RELEASE_PULSE_EN builds the release pulse
// register; otherwise release_pulse is tied to 0.
// Ports:
//   Clk100MHz     - system clock
//   reset         - synchronous, active-high reset
//   sync_sig      - synchronised raw button level
//   btn_level     - debounced level (registered)
//   press_pulse   - one-cycle pulse on accepted 0->1 (registered)
//   release_pulse - one-cycle pulse on accepted 1->0 (registered, optional)
module debounce_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic Clk100MHz,
  input  logic reset,
  input  logic sync_sig,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic             release_q, release_d;
`endif

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    release_d = 1'b0;
`endif
    // Matching input restarts the run, discarding any short glitch
    if (sync_sig != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_sig;
        press_d = sync_sig;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        release_d = ~sync_sig;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk100MHz) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  always_ff @(posedge Clk100MHz) begin
    if (reset) begin
      release_q <= 1'b0;
    end else begin
      release_q <= release_d;
    end
  end

  assign release_pulse = release_q;
`else
  assign release_pulse = 1'b0;
`endif

  assign btn_level   = level_q;
  assign press_pulse = press_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// Multi-channel button debouncer with press/release pulse generation.
// Consumes the synchroniser's sync_sig bus and emits debounced levels
// plus one-cycle pulses; every channel is an independent debounce_chan.
// Optional macro DEBOUNCE_RELEASE_PULSE_EN enables release_pulse
// (otherwise it reads constant 0).
// Ports:
//   Clk100MHz     - 100 MHz system clock
//   reset         - synchronous, active-high reset
//   sync_sig      - WIDTH synchronised raw button levels
//   btn_level     - WIDTH debounced levels
//   press_pulse   - WIDTH one-cycle press pulses
//   release_pulse - WIDTH one-cycle release pulses
module button_debounce_pulse
  import craps_pkg::*;
#(
  parameter int unsigned WIDTH           = BTN_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic             Clk100MHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] sync_sig,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .Clk100MHz    (Clk100MHz),
      .reset        (reset),
      .sync_sig     (sync_sig[i]),
      .btn_level    (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule
